// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the arbiter state encoding, the default character width and the
// clock/baud constants used by both the arbiter and the transmitter.
// No ports (package).
package uart_pkg;

    // Arbiter sequencing states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int unsigned DEF_DATA_WIDTH = 8;

    localparam int unsigned CLK_FREQ_HZ  = 50_000_000;
    localparam int unsigned BAUD_RATE    = 115_200;
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker.
// Searches req starting at last+1 upward with wrap and returns the first
// set index. Shared with the receiver-side distributor.
// Ports:
//   req    in   NUM_REQ    request vector
//   last   in   IDX_WIDTH  index granted most recently (lowest priority)
//   winner out  IDX_WIDTH  selected index (0 when valid is low)
//   valid  out  1          at least one request is set
module rr_select
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] last,
    output logic [IDX_WIDTH-1:0] winner,
    output logic                 valid
);

    logic [IDX_WIDTH-1:0] cand;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        cand   = '0;
        // i = 1 is the highest priority slot, i = NUM_REQ wraps back to last.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_WIDTH'((32'(last) + i) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ clients.
// Each character is sequenced IDLE -> SEND -> WAIT_BUSY -> WAIT_DONE -> IDLE.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req             per-requester request, held until grant_ack
//   req_data        packed characters, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_parity      per-requester parity mode (1 odd, 0 even)
//   grant_ack       one-hot one-cycle pulse, character captured
//   tx_send         one-cycle start pulse to the transmitter
//   tx_din          character to transmitter, held until return to IDLE
//   tx_parity_mode  parity mode to transmitter, held like tx_din
//   tx_busy         transmitter busy status
//   owner           index of the requester being served
//   arb_busy        high whenever not in IDLE
//   err_timeout     one-cycle pulse when the transmitter never went busy
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned BUSY_TIMEOUT = 16,
    parameter int unsigned TO_WIDTH     = 5,
    parameter int unsigned IDX_WIDTH    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_parity,
    output logic [NUM_REQ-1:0]            grant_ack,
    output logic                          tx_send,
    output logic [DATA_WIDTH-1:0]         tx_din,
    output logic                          tx_parity_mode,
    input  logic                          tx_busy,
    output logic [IDX_WIDTH-1:0]          owner,
    output logic                          arb_busy,
    output logic                          err_timeout
);

    // The counter clears in SEND and the pulse is registered, so deciding on
    // count BUSY_TIMEOUT-2 places err_timeout exactly BUSY_TIMEOUT cycles
    // after tx_send.
    localparam logic [TO_WIDTH-1:0]  TO_LAST   = TO_WIDTH'(BUSY_TIMEOUT - 2);
    localparam logic [IDX_WIDTH-1:0] LAST_INIT = IDX_WIDTH'(NUM_REQ - 1);

    arb_state_e                state_q, state_d;
    logic [NUM_REQ-1:0]        grant_ack_q, grant_ack_d;
    logic                      tx_send_q, tx_send_d;
    logic [DATA_WIDTH-1:0]     tx_din_q, tx_din_d;
    logic                      tx_parity_q, tx_parity_d;
    logic [IDX_WIDTH-1:0]      owner_q, owner_d;
    logic [IDX_WIDTH-1:0]      last_q, last_d;
    logic [TO_WIDTH-1:0]       cnt_q, cnt_d;
    logic                      arb_busy_q, arb_busy_d;
    logic                      err_q, err_d;

    logic [IDX_WIDTH-1:0]      win_idx;
    logic                      win_valid;

    rr_select #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_select (
        .req    (req),
        .last   (last_q),
        .winner (win_idx),
        .valid  (win_valid)
    );

    always_comb begin
        state_d     = state_q;
        grant_ack_d = '0;
        tx_send_d   = 1'b0;
        tx_din_d    = tx_din_q;
        tx_parity_d = tx_parity_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    tx_din_d    = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    tx_parity_d = req_parity[win_idx];
                    owner_d     = win_idx;
                    last_d      = win_idx;
                    // Ack and start pulse are registered, so both appear in SEND.
                    grant_ack_d = NUM_REQ'(1) << win_idx;
                    tx_send_d   = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        arb_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_ack_q <= '0;
            tx_send_q   <= 1'b0;
            tx_din_q    <= '0;
            tx_parity_q <= 1'b0;
            owner_q     <= '0;
            last_q      <= LAST_INIT;
            cnt_q       <= '0;
            arb_busy_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_ack_q <= grant_ack_d;
            tx_send_q   <= tx_send_d;
            tx_din_q    <= tx_din_d;
            tx_parity_q <= tx_parity_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            arb_busy_q  <= arb_busy_d;
            err_q       <= err_d;
        end
    end

    assign grant_ack      = grant_ack_q;
    assign tx_send        = tx_send_q;
    assign tx_din         = tx_din_q;
    assign tx_parity_mode = tx_parity_q;
    assign owner          = owner_q;
    assign arb_busy       = arb_busy_q;
    assign err_timeout    = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural UART transmitter
// and a serial decoder on its line output.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int DW           = 8;
    localparam int BUSY_TIMEOUT = 16;
    localparam int BIT_CLKS     = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*DW-1:0]  req_data;
    logic [NUM_REQ-1:0]     req_parity;
    logic [NUM_REQ-1:0]     grant_ack;
    logic                   tx_send;
    logic [DW-1:0]          tx_din;
    logic                   tx_parity_mode;
    logic                   tx_busy;
    logic [1:0]             owner;
    logic                   arb_busy;
    logic                   err_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_WIDTH   (DW),
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .TO_WIDTH     (5),
        .IDX_WIDTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_data       (req_data),
        .req_parity     (req_parity),
        .grant_ack      (grant_ack),
        .tx_send        (tx_send),
        .tx_din         (tx_din),
        .tx_parity_mode (tx_parity_mode),
        .tx_busy        (tx_busy),
        .owner          (owner),
        .arb_busy       (arb_busy),
        .err_timeout    (err_timeout)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: start, 8 data LSB first, parity, stop.
    logic        tx_line = 1'b1;
    logic        m_stuck = 1'b0;
    logic [10:0] m_frame;
    logic [3:0]  m_idx;
    int          m_tick;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy <= 1'b0;
            tx_line <= 1'b1;
            m_frame <= '0;
            m_idx   <= '0;
            m_tick  <= 0;
        end else if (!tx_busy) begin
            if (tx_send && !m_stuck) begin
                m_frame <= {1'b1, (tx_parity_mode ? ~^tx_din : ^tx_din), tx_din, 1'b0};
                tx_busy <= 1'b1;
                m_idx   <= '0;
                m_tick  <= 0;
                tx_line <= 1'b0;
            end
        end else if (m_tick == BIT_CLKS - 1) begin
            m_tick <= 0;
            if (m_idx == 4'd10) begin
                tx_busy <= 1'b0;
                tx_line <= 1'b1;
            end else begin
                m_idx   <= m_idx + 4'd1;
                tx_line <= m_frame[m_idx + 4'd1];
            end
        end else begin
            m_tick <= m_tick + 1;
        end
    end

    // Serial decoder, samples near mid-bit.
    int         rx_cnt = 0;
    logic [7:0] rx_data, rx_sh;
    logic       rx_par, rx_stop;

    always begin
        @(negedge tx_line);
        repeat (BIT_CLKS / 2) @(negedge clk);
        if (tx_line == 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                repeat (BIT_CLKS) @(negedge clk);
                rx_sh[i] = tx_line;
            end
            repeat (BIT_CLKS) @(negedge clk);
            rx_par = tx_line;
            repeat (BIT_CLKS) @(negedge clk);
            rx_stop = tx_line;
            rx_data = rx_sh;
            rx_cnt++;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (!arb_busy) break;
        end
        check("wait_idle", {31'd0, arb_busy}, 32'd0);
    endtask

    task automatic wait_send(input int budget, output int at);
        at = -1;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (tx_send) begin
                at = cyc;
                break;
            end
        end
        check("wait_send", {31'd0, tx_send}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " grant_ack"}, {28'd0, grant_ack}, 32'd0);
        check({tag, " tx_send"}, {31'd0, tx_send}, 32'd0);
        check({tag, " tx_din"}, {24'd0, tx_din}, 32'd0);
        check({tag, " tx_parity"}, {31'd0, tx_parity_mode}, 32'd0);
        check({tag, " owner"}, {30'd0, owner}, 32'd0);
        check({tag, " arb_busy"}, {31'd0, arb_busy}, 32'd0);
        check({tag, " err_timeout"}, {31'd0, err_timeout}, 32'd0);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  par;
        logic [3:0]  ack;
        logic [7:0]  din;
        logic        p;
        logic [1:0]  own;
    } vec_t;

    vec_t vt[8];

    initial begin
        int k, s_at, e_at, rxc0;
        logic [7:0] exp_a[4];
        logic [1:0] got_own[4];

        // Pointer sequence starts at last = 3 (left there by the 4-way burst).
        vt[0] = '{4'b0001, 32'hD3C2B155, 4'b0000, 4'b0001, 8'h55, 1'b0, 2'd0};
        vt[1] = '{4'b0011, 32'h00001277, 4'b0010, 4'b0010, 8'h12, 1'b1, 2'd1};
        vt[2] = '{4'b0011, 32'h000034E1, 4'b0011, 4'b0001, 8'hE1, 1'b1, 2'd0};
        vt[3] = '{4'b1100, 32'h9C8B0000, 4'b0100, 4'b0100, 8'h8B, 1'b1, 2'd2};
        vt[4] = '{4'b1100, 32'h9C8B0000, 4'b0100, 4'b1000, 8'h9C, 1'b0, 2'd3};
        vt[5] = '{4'b1000, 32'hF0000000, 4'b1000, 4'b1000, 8'hF0, 1'b1, 2'd3};
        vt[6] = '{4'b0110, 32'h00665500, 4'b0100, 4'b0010, 8'h55, 1'b0, 2'd1};
        vt[7] = '{4'b1111, 32'h44332211, 4'b1010, 4'b0100, 8'h33, 1'b0, 2'd2};

        rst        = 1'b1;
        req        = '0;
        req_data   = '0;
        req_parity = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // All four request together; served 0,1,2,3 one frame at a time.
        exp_a    = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        req      = 4'hF;
        req_data = 32'hA3A2A1A0;
        k        = 0;
        for (int t = 0; t < 800 && k < 4; t++) begin
            @(negedge clk);
            if (tx_send) begin
                check($sformatf("burst din %0d", k), {24'd0, tx_din}, {24'd0, exp_a[k]});
                check($sformatf("burst ack %0d", k), {28'd0, grant_ack}, 32'd1 << k);
                check($sformatf("burst busy low %0d", k), {31'd0, tx_busy}, 32'd0);
                req = req & ~grant_ack;
                k++;
            end
        end
        check("burst count", k, 4);
        wait_idle(200);

        // Single-grant vectors from IDLE.
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            req        = vt[v].req;
            req_data   = vt[v].data;
            req_parity = vt[v].par;
            @(negedge clk);
            check($sformatf("v%0d tx_send", v), {31'd0, tx_send}, 32'd1);
            check($sformatf("v%0d grant_ack", v), {28'd0, grant_ack}, {28'd0, vt[v].ack});
            check($sformatf("v%0d tx_din", v), {24'd0, tx_din}, {24'd0, vt[v].din});
            check($sformatf("v%0d parity", v), {31'd0, tx_parity_mode}, {31'd0, vt[v].p});
            check($sformatf("v%0d owner", v), {30'd0, owner}, {30'd0, vt[v].own});
            req = '0;
            repeat (10) @(negedge clk);
            check($sformatf("v%0d ack pulse", v), {28'd0, grant_ack}, 32'd0);
            check($sformatf("v%0d din held", v), {24'd0, tx_din}, {24'd0, vt[v].din});
            check($sformatf("v%0d owner held", v), {30'd0, owner}, {30'd0, vt[v].own});
            wait_idle(200);
        end

        // req0 and req2 held continuously: must alternate.
        req      = 4'b0101;
        req_data = 32'h00BB00AA;
        k        = 0;
        for (int t = 0; t < 800 && k < 4; t++) begin
            @(negedge clk);
            if (tx_send) begin
                got_own[k] = owner;
                k++;
                if (k == 4) req = '0;
            end
        end
        check("alt count", k, 4);
        check("alt grant 0", {30'd0, got_own[0]}, 32'd0);
        check("alt grant 1", {30'd0, got_own[1]}, 32'd2);
        check("alt grant 2", {30'd0, got_own[2]}, 32'd0);
        check("alt grant 3", {30'd0, got_own[3]}, 32'd2);
        wait_idle(200);

        // Transmitter never goes busy: timeout, then pending req3 is served.
        m_stuck  = 1'b1;
        req      = 4'b0010;
        req_data = 32'h77001100;
        wait_send(10, s_at);
        check("to first ack", {28'd0, grant_ack}, 32'b0010);
        req  = 4'b1000;
        e_at = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (err_timeout) begin
                e_at = cyc;
                break;
            end
        end
        check("to err delay", e_at - s_at, BUSY_TIMEOUT);
        check("to arb_busy low", {31'd0, arb_busy}, 32'd0);
        @(negedge clk);
        check("to err one cycle", {31'd0, err_timeout}, 32'd0);
        check("to next send", {31'd0, tx_send}, 32'd1);
        check("to next ack", {28'd0, grant_ack}, 32'b1000);
        check("to next din", {24'd0, tx_din}, 32'h77);
        m_stuck = 1'b0;
        req     = '0;
        wait_idle(200);

        // Reset while in WAIT_DONE.
        req        = 4'b0100;
        req_data   = 32'h005A0000;
        req_parity = 4'b0100;
        wait_send(10, s_at);
        req = '0;
        repeat (6) @(negedge clk);
        check("rst pre busy", {31'd0, tx_busy}, 32'd1);
        check("rst pre arb_busy", {31'd0, arb_busy}, 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("async rst");
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check($sformatf("rst no send %0d", t), {31'd0, tx_send}, 32'd0);
        end
        rst        = 1'b0;
        req        = 4'b0011;
        req_data   = 32'h00002211;
        req_parity = '0;
        wait_send(10, s_at);
        check("post rst ack", {28'd0, grant_ack}, 32'b0001);
        check("post rst din", {24'd0, tx_din}, 32'h11);
        req = req & ~grant_ack;
        wait_send(200, s_at);
        check("post rst ack2", {28'd0, grant_ack}, 32'b0010);
        req = '0;
        wait_idle(200);

        // Odd parity frame through the serial decoder.
        repeat (100) @(negedge clk);
        rxc0       = rx_cnt;
        req        = 4'b0010;
        req_data   = 32'h00000700;
        req_parity = 4'b0010;
        wait_send(10, s_at);
        check("par mode", {31'd0, tx_parity_mode}, 32'd1);
        req = '0;
        wait_idle(200);
        for (int t = 0; t < 20 && rx_cnt == rxc0; t++) @(negedge clk);
        check("rx frames", rx_cnt - rxc0, 1);
        check("rx data", {24'd0, rx_data}, 32'h07);
        check("rx parity bit", {31'd0, rx_par}, 32'd0);
        check("rx stop", {31'd0, rx_stop}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
